// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: op select and FSM state.
package hilo_muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MULDIV_OP_MULT  = 2'd0,
    MULDIV_OP_MULTU = 2'd1,
    MULDIV_OP_DIV   = 2'd2,
    MULDIV_OP_DIVU  = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle for DIV_CYC cycles after start_i.
// done_o is high during the final step; quot_o/rem_o hold the result from the following cycle.
module hilo_muldiv_ctrl_div_iter #(
  parameter int DATA_W  = 32,
  parameter int DIV_CYC = 32
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              abort_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o
);

  localparam int CNT_W = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;

  logic              run_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] dvs_q;

  logic [DATA_W:0]   shifted;
  logic              ge;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quot_step;

  // quot_q starts as the dividend and shifts its bits out into the partial remainder
  // while quotient bits shift in from the bottom.
  always_comb begin
    shifted   = {rem_q, quot_q[DATA_W-1]};
    ge        = shifted >= {1'b0, dvs_q};
    rem_step  = ge ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
    quot_step = {quot_q[DATA_W-2:0], ge};
  end

  assign done_o = run_q && (cnt_q == CNT_W'(DIV_CYC - 1));
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
    end else if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (run_q) begin
      rem_q  <= rem_step;
      quot_q <= quot_step;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage mul/div sequencer owning HI/LO: MUL_LAT+1 / DIV_CYC+1 stall cycles per op incl. accept.
// stall_o freezes PC..EX while an op is accepted or in flight; flush_o aborts with no HI/LO write.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_CYC = 32
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              flush_i,
  input  logic              op_valid_i,
  input  logic [1:0]        op_sel_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              mt_we_i,
  input  logic              mt_hi_i,
  input  logic [DATA_W-1:0] mt_wdata_i,
  input  logic              mf_req_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_rdata_o,
  output logic [DATA_W-1:0] lo_rdata_o,
  output logic              busy_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  muldiv_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  muldiv_op_e          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                stall;

  muldiv_op_e          op_in;
  logic                in_signed_div;
  logic [DATA_W-1:0]   dvd_mag, dvs_mag;
  logic                div_start, div_done;
  logic [DATA_W-1:0]   div_quot, div_rem;

  logic                mul_sgn;
  logic [2*DATA_W-1:0] mul_a, mul_b;
  logic                q_neg, r_neg;
  logic [DATA_W-1:0]   div_lo, div_hi;

  assign op_in         = muldiv_op_e'(op_sel_i);
  assign in_signed_div = (op_in == MULDIV_OP_DIV);
  assign dvd_mag = (in_signed_div && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
  assign dvs_mag = (in_signed_div && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;

  // Sign-extending to the full product width makes one unsigned '*' serve both MULT and MULTU.
  assign mul_sgn = op_is_signed(op_q);
  assign mul_a   = {{DATA_W{mul_sgn & a_q[DATA_W-1]}}, a_q};
  assign mul_b   = {{DATA_W{mul_sgn & b_q[DATA_W-1]}}, b_q};

  assign q_neg  = (op_q == MULDIV_OP_DIV) && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
  assign r_neg  = (op_q == MULDIV_OP_DIV) && a_q[DATA_W-1];
  assign div_lo = q_neg ? -div_quot : div_quot;
  assign div_hi = r_neg ? -div_rem : div_rem;

  hilo_muldiv_ctrl_div_iter #(
    .DATA_W  (DATA_W),
    .DIV_CYC (DIV_CYC)
  ) u_div_iter (
    .clk_i      (clk_i),
    .resetn_i   (resetn_i),
    .start_i    (div_start),
    .dividend_i (dvd_mag),
    .divisor_i  (dvs_mag),
    .abort_i    (flush_i),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall     = 1'b0;
    div_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall = op_valid_i;
        if (op_valid_i && !flush_i) begin
          op_d  = op_in;
          a_d   = src_a_i;
          b_d   = src_b_i;
          cnt_d = '0;
          if (op_is_div(op_in)) begin
            state_d   = ST_DIV;
            div_start = 1'b1;
          end else begin
            state_d = ST_MUL;
          end
        end else if (mt_we_i && !op_valid_i) begin
          if (mt_hi_i) hi_d = mt_wdata_i;
          else         lo_d = mt_wdata_i;
        end
      end
      ST_MUL: begin
        stall = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          prod_d = mul_a * mul_b;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == MUL_LAST) state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        stall = 1'b1;
        if (flush_i)       state_d = ST_IDLE;
        else if (div_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          if (op_is_div(op_q)) begin
            hi_d = div_hi;
            lo_d = div_lo;
          end else begin
            hi_d = prod_q[2*DATA_W-1:DATA_W];
            lo_d = prod_q[DATA_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (mf_req_i && (state_q == ST_MUL || state_q == ST_DIV)) stall = 1'b1;
    // The flushed instruction is leaving EX, so it must not hold the pipe.
    if (flush_i) stall = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MULDIV_OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stall_o    = stall;
  assign hi_rdata_o = hi_q;
  assign lo_rdata_o = lo_q;
  assign busy_o     = (state_q != ST_IDLE);

  mt_we_only_when_idle: assert property (
    @(posedge clk_i) disable iff (!resetn_i)
    mt_we_i |-> (state_q == ST_IDLE && !op_valid_i)
  );

endmodule
